// File: rtl/regfile_pkg.sv
// Shared constants for the CPU pair register file: default geometry,
// pair indices and reset values of the stack-pointer and program-counter pairs.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 8;
    localparam int REGFILE_NREGS  = 12;

    localparam int PAIR_AB = 0;
    localparam int PAIR_CD = 1;
    localparam int PAIR_EF = 2;
    localparam int PAIR_HL = 3;
    localparam int PAIR_SP = 4;
    localparam int PAIR_PC = 5;

    localparam logic [2*REGFILE_DATA_W-1:0] SP_RESET_DEF = 16'hFFFF;
    localparam logic [2*REGFILE_DATA_W-1:0] PC_RESET_DEF = 16'h0000;

endpackage

// File: rtl/pair_stepper.sv
// Combinational +/-1 on a register pair, with a flag for all-ones/zero wrap-around.
module pair_stepper #(
    parameter int W = 16
) (
    input  logic [W-1:0] pair_in,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] pair_out,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        pair_out = pair_in;
        wrap     = 1'b0;
        if (inc && !dec) begin
            pair_out = pair_in + ONE;
            wrap     = &pair_in;
        end else if (dec && !inc) begin
            pair_out = pair_in - ONE;
            wrap     = ~|pair_in;
        end
    end

endmodule

// File: rtl/pair_regfile.sv
// Byte register file organised as pairs: two ALU read ports with i_dat bypass,
// a pair address port, byte/pair writes and a single pair stepper with wrap flag.
module pair_regfile
    import regfile_pkg::*;
#(
    parameter int                        DATA_W   = REGFILE_DATA_W,
    parameter int                        NREGS    = REGFILE_NREGS,
    parameter int                        SEL_W    = 4,
    parameter int                        PSEL_W   = 3,
    parameter int                        SP_PAIR  = PAIR_SP,
    parameter int                        PC_PAIR  = PAIR_PC,
    parameter logic [2*DATA_W-1:0]       SP_RESET = SP_RESET_DEF,
    parameter logic [2*DATA_W-1:0]       PC_RESET = PC_RESET_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_W-1:0]     i_dat,
    input  logic                  i_load,
    input  logic [SEL_W-1:0]      i_load_reg_sel,
    input  logic                  i_pair_load,
    input  logic [PSEL_W-1:0]     i_pair_sel,
    input  logic [2*DATA_W-1:0]   i_pair_dat,
    input  logic [PSEL_W-1:0]     i_step_sel,
    input  logic                  i_inc,
    input  logic                  i_dec,
    input  logic [SEL_W-1:0]      i_alu_l_sel,
    input  logic [SEL_W-1:0]      i_alu_r_sel,
    input  logic [PSEL_W-1:0]     i_addr_sel,
    output logic [DATA_W-1:0]     o_alu_l,
    output logic [DATA_W-1:0]     o_alu_r,
    output logic [2*DATA_W-1:0]   o_addr,
    output logic                  o_wrap
);

    localparam int NPAIRS = NREGS / 2;

    logic [DATA_W-1:0]   regs    [NREGS];
    logic [DATA_W-1:0]   reg_nxt [NREGS];
    logic [DATA_W-1:0]   rst_val [NREGS];
    logic [NREGS-1:0]    byte_we;
    logic [NPAIRS-1:0]   pair_we;
    logic [NPAIRS-1:0]   touched;

    logic [2*DATA_W-1:0] step_cur;
    logic [2*DATA_W-1:0] step_nxt;
    logic                step_wrap;
    logic                step_hit;
    logic                step_blocked;
    logic                step_go;

    // Read muxes; unmatched selects fall through to the bypass or zero.
    always_comb begin
        o_alu_l      = i_dat;
        o_alu_r      = i_dat;
        o_addr       = '0;
        step_cur     = '0;
        step_hit     = 1'b0;
        step_blocked = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (i_alu_l_sel == SEL_W'(r)) o_alu_l = regs[r];
            if (i_alu_r_sel == SEL_W'(r)) o_alu_r = regs[r];
        end
        for (int p = 0; p < NPAIRS; p++) begin
            if (i_addr_sel == PSEL_W'(p)) o_addr = {regs[2*p+1], regs[2*p]};
            if (i_step_sel == PSEL_W'(p)) begin
                step_cur     = {regs[2*p+1], regs[2*p]};
                step_hit     = 1'b1;
                step_blocked = touched[p];
            end
        end
    end

    pair_stepper #(.W(2*DATA_W)) u_stepper (
        .pair_in  (step_cur),
        .inc      (i_inc),
        .dec      (i_dec),
        .pair_out (step_nxt),
        .wrap     (step_wrap)
    );

    // A step only lands when it targets a real pair that sees no write this cycle.
    assign step_go = step_hit && !step_blocked && (i_inc ^ i_dec);

    for (genvar p = 0; p < NPAIRS; p++) begin : g_pair
        assign pair_we[p] = i_pair_load && (i_pair_sel == PSEL_W'(p));
        assign touched[p] = pair_we[p] || byte_we[2*p] || byte_we[2*p+1];
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        localparam int                  P        = r / 2;
        localparam logic [2*DATA_W-1:0] PAIR_RST = (P == SP_PAIR) ? SP_RESET :
                                                   (P == PC_PAIR) ? PC_RESET : '0;
        logic [DATA_W-1:0] pair_half;
        logic [DATA_W-1:0] step_half;

        if (r % 2 == 1) begin : g_hi
            assign pair_half  = i_pair_dat[2*DATA_W-1:DATA_W];
            assign step_half  = step_nxt[2*DATA_W-1:DATA_W];
            assign rst_val[r] = PAIR_RST[2*DATA_W-1:DATA_W];
        end else begin : g_lo
            assign pair_half  = i_pair_dat[DATA_W-1:0];
            assign step_half  = step_nxt[DATA_W-1:0];
            assign rst_val[r] = PAIR_RST[DATA_W-1:0];
        end

        assign byte_we[r] = i_load && (i_load_reg_sel == SEL_W'(r));
        assign reg_nxt[r] = byte_we[r]                                 ? i_dat     :
                            pair_we[P]                                 ? pair_half :
                            (step_go && i_step_sel == PSEL_W'(P))      ? step_half :
                                                                         regs[r];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= rst_val[r];
            o_wrap <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) regs[r] <= reg_nxt[r];
            o_wrap <= step_go && step_wrap;
        end
    end

endmodule

// File: tb/tb_pair_regfile.sv
// Directed bench for pair_regfile: expectations are queued as stimulus is driven
// and popped when the corresponding output is sampled.
module tb_pair_regfile;

    localparam int DATA_W = 8;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic [7:0]    i_dat;
    logic          i_load;
    logic [3:0]    i_load_reg_sel;
    logic          i_pair_load;
    logic [2:0]    i_pair_sel;
    logic [15:0]   i_pair_dat;
    logic [2:0]    i_step_sel;
    logic          i_inc;
    logic          i_dec;
    logic [3:0]    i_alu_l_sel;
    logic [3:0]    i_alu_r_sel;
    logic [2:0]    i_addr_sel;
    logic [7:0]    o_alu_l;
    logic [7:0]    o_alu_r;
    logic [15:0]   o_addr;
    logic          o_wrap;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    pair_regfile dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_dat          (i_dat),
        .i_load         (i_load),
        .i_load_reg_sel (i_load_reg_sel),
        .i_pair_load    (i_pair_load),
        .i_pair_sel     (i_pair_sel),
        .i_pair_dat     (i_pair_dat),
        .i_step_sel     (i_step_sel),
        .i_inc          (i_inc),
        .i_dec          (i_dec),
        .i_alu_l_sel    (i_alu_l_sel),
        .i_alu_r_sel    (i_alu_r_sel),
        .i_addr_sel     (i_addr_sel),
        .o_alu_l        (o_alu_l),
        .o_alu_r        (o_alu_r),
        .o_addr         (o_addr),
        .o_wrap         (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic read_pair(input logic [2:0] p, input string tag);
        i_addr_sel = p;
        #1;
        check(tag, {16'h0, o_addr});
    endtask

    initial begin
        i_reset = 1'b1; i_dat = '0; i_load = 1'b0; i_load_reg_sel = '0;
        i_pair_load = 1'b0; i_pair_sel = '0; i_pair_dat = '0;
        i_step_sel = '0; i_inc = 1'b0; i_dec = 1'b0;
        i_alu_l_sel = '0; i_alu_r_sel = '0; i_addr_sel = '0;

        // Reset state
        push("rst_sp", 32'hFFFF);
        push("rst_pc", 32'h0000);
        push("rst_reg0", 32'h00);
        push("rst_reg8", 32'hFF);
        push("rst_wrap", 32'h0);
        tick(); tick();
        i_reset = 1'b0;
        read_pair(3'd4, "rst_sp");
        read_pair(3'd5, "rst_pc");
        i_alu_l_sel = 4'd0; i_alu_r_sel = 4'd8; #1;
        check("rst_reg0", {24'h0, o_alu_l});
        check("rst_reg8", {24'h0, o_alu_r});
        check("rst_wrap", {31'h0, o_wrap});

        // Byte load and bypass
        i_load = 1'b1; i_load_reg_sel = 4'd3; i_dat = 8'h5A;
        push("byte_ld", 32'h5A);
        tick();
        i_load = 1'b0; i_alu_l_sel = 4'd3; #1;
        check("byte_ld", {24'h0, o_alu_l});
        push("bypass", 32'hC3);
        i_alu_r_sel = 4'd15; i_dat = 8'hC3; #1;
        check("bypass", {24'h0, o_alu_r});
        push("pair1_hi_rd", 32'h5A00);
        read_pair(3'd1, "pair1_hi_rd");

        // PC pair load, carry and borrow
        i_pair_load = 1'b1; i_pair_sel = 3'd5; i_pair_dat = 16'h12FF;
        push("pc_ld", 32'h12FF);
        tick();
        i_pair_load = 1'b0;
        read_pair(3'd5, "pc_ld");
        i_step_sel = 3'd5; i_inc = 1'b1;
        push("pc_inc", 32'h1300);
        push("pc_inc_wrap", 32'h0);
        tick();
        i_inc = 1'b0;
        read_pair(3'd5, "pc_inc");
        check("pc_inc_wrap", {31'h0, o_wrap});
        i_dec = 1'b1;
        push("pc_dec1", 32'h12FF);
        tick();
        read_pair(3'd5, "pc_dec1");
        push("pc_dec2", 32'h12FE);
        tick();
        i_dec = 1'b0;
        read_pair(3'd5, "pc_dec2");

        // SP wrap-around both directions
        i_step_sel = 3'd4; i_inc = 1'b1;
        push("sp_inc", 32'h0000);
        push("sp_inc_wrap", 32'h1);
        push("sp_wrap_clr", 32'h0);
        tick();
        i_inc = 1'b0;
        read_pair(3'd4, "sp_inc");
        check("sp_inc_wrap", {31'h0, o_wrap});
        tick();
        check("sp_wrap_clr", {31'h0, o_wrap});
        i_dec = 1'b1;
        push("sp_dec", 32'hFFFF);
        push("sp_dec_wrap", 32'h1);
        push("sp_dec_wrap_clr", 32'h0);
        tick();
        i_dec = 1'b0;
        read_pair(3'd4, "sp_dec");
        check("sp_dec_wrap", {31'h0, o_wrap});
        tick();
        check("sp_dec_wrap_clr", {31'h0, o_wrap});

        // Byte write beats pair write on its byte
        i_pair_load = 1'b1; i_pair_sel = 3'd1; i_pair_dat = 16'hABCD;
        i_load = 1'b1; i_load_reg_sel = 4'd2; i_dat = 8'h11;
        push("byte_over_pair", 32'hAB11);
        tick();
        i_pair_load = 1'b0; i_load = 1'b0;
        read_pair(3'd1, "byte_over_pair");

        // Step suppressed by a write to its pair, no wrap reported
        i_pair_load = 1'b1; i_pair_sel = 3'd0; i_pair_dat = 16'hFFFF;
        tick();
        i_pair_load = 1'b0;
        i_step_sel = 3'd0; i_inc = 1'b1;
        i_load = 1'b1; i_load_reg_sel = 4'd1; i_dat = 8'h22;
        push("step_suppr", 32'h22FF);
        push("step_suppr_wrap", 32'h0);
        tick();
        i_inc = 1'b0; i_load = 1'b0;
        read_pair(3'd0, "step_suppr");
        check("step_suppr_wrap", {31'h0, o_wrap});

        // Inc and dec together leave the pair alone
        i_step_sel = 3'd1; i_inc = 1'b1; i_dec = 1'b1;
        push("inc_dec_both", 32'hAB11);
        push("inc_dec_wrap", 32'h0);
        tick();
        i_inc = 1'b0; i_dec = 1'b0;
        read_pair(3'd1, "inc_dec_both");
        check("inc_dec_wrap", {31'h0, o_wrap});

        // Back-to-back increments on pair 1
        i_inc = 1'b1;
        tick(); tick();
        i_inc = 1'b0;
        push("b2b_inc", 32'hAB13);
        read_pair(3'd1, "b2b_inc");

        // Reset overrides a simultaneous PC load
        i_reset = 1'b1; i_pair_load = 1'b1; i_pair_sel = 3'd5; i_pair_dat = 16'h5555;
        push("rst_over_ld", 32'h0000);
        push("rst_pair1", 32'h0000);
        push("rst_sp2", 32'hFFFF);
        tick();
        i_reset = 1'b0; i_pair_load = 1'b0;
        read_pair(3'd5, "rst_over_ld");
        read_pair(3'd1, "rst_pair1");
        read_pair(3'd4, "rst_sp2");

        // Out-of-range byte select writes nothing
        i_load = 1'b1; i_load_reg_sel = 4'd13; i_dat = 8'h99;
        tick();
        i_load = 1'b0;
        for (int p = 0; p < 6; p++) begin
            push($sformatf("oor_pair%0d", p), (p == 4) ? 32'hFFFF : 32'h0000);
            read_pair(3'(p), $sformatf("oor_pair%0d", p));
        end
        i_alu_l_sel = 4'd13; i_dat = 8'h3C;
        push("oor_bypass", 32'h3C);
        #1;
        check("oor_bypass", {24'h0, o_alu_l});
        push("oor_addr", 32'h0000);
        read_pair(3'd7, "oor_addr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
